// File: rtl/wiegand_pkg.sv
// Shared Wiegand definitions: frame geometry, receive status codes and the
// state encoding used by both the transmitter and receiver sides.
package wiegand_pkg;

    localparam int WG_BITS    = 26;
    localparam int WG_ID_BITS = 24;

    localparam logic [1:0] WG_OK   = 2'd0;
    localparam logic [1:0] WG_PAR  = 2'd1;
    localparam logic [1:0] WG_LEN  = 2'd2;
    localparam logic [1:0] WG_LINE = 2'd3;

    typedef enum logic [2:0] {
        ST_ARMED,
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } wg_state_t;

endpackage

// File: rtl/wiegand_line_sync.sv
// Two-flop synchronizer for the two Wiegand data lines.
module wiegand_line_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [1:0] sync_p0;
    logic [1:0] sync_p1;

    // Reset to 11 so a line already high at reset release is never mistaken
    // for a fresh idle-to-pulse transition; the receiver waits for a true 00.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    assign dout = sync_p1;

endmodule

// File: rtl/wiegand_in.sv
// Wiegand 26-bit receiver: filters D0/D1 pulses, assembles a frame, closes it
// on an idle gap and reports the frame with a length/parity/line-fault status.
module wiegand_in
    import wiegand_pkg::*;
#(
    parameter int MIN_PULSE   = 20,
    parameter int MAX_PULSE   = 1000,
    parameter int GAP_TIMEOUT = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            wigend,
    output logic [WG_BITS-1:0]    data,
    output logic [WG_ID_BITS-1:0] id,
    output logic                  valid,
    output logic [1:0]            err_code,
    output logic                  busy
);

    localparam int WW = $clog2(MAX_PULSE + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    localparam logic [WW-1:0] W_ACCEPT = WW'(MIN_PULSE - 1);
    localparam logic [WW-1:0] W_MIN    = WW'(MIN_PULSE);
    localparam logic [WW-1:0] W_MAX    = WW'(MAX_PULSE);
    localparam logic [GW-1:0] G_LAST   = GW'(GAP_TIMEOUT - 1);

    function automatic logic [WW-1:0] width_inc(input logic [WW-1:0] w);
        return (w == {WW{1'b1}}) ? w : w + 1'b1;
    endfunction

    function automatic logic [4:0] cnt_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

    function automatic logic parity_ok(input logic [WG_BITS-1:0] f);
        return (^f[25:13] == 1'b0) && (^f[12:0] == 1'b1);
    endfunction

    logic [1:0]         s;
    wg_state_t          state_q, state_d;
    logic [WW-1:0]      width_q, width_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [1:0]         line_q, line_d;
    logic [WG_BITS-1:0] shreg_q, shreg_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic [WG_BITS-1:0] data_q, data_d;
    logic [1:0]         err_q, err_d;

    wiegand_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (wigend),
        .dout (s)
    );

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        gap_d     = gap_q;
        line_d    = line_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        fault_d   = fault_q;
        data_d    = data_q;
        err_d     = err_q;

        unique case (state_q)
            ST_ARMED: begin
                if (s == 2'b00) state_d = ST_IDLE;
            end
            ST_IDLE, ST_GAP: begin
                if (s != 2'b00) begin
                    state_d = ST_PULSE;
                    width_d = WW'(1);
                    line_d  = s;
                    if (s == 2'b11) fault_d = 1'b1;
                end else if (state_q == ST_GAP) begin
                    if (gap_q == G_LAST) begin
                        // Frame closes: publish it with its status, then start clean.
                        state_d = ST_DONE;
                        data_d  = shreg_q;
                        if (fault_q)                           err_d = WG_LINE;
                        else if (bit_cnt_q != 5'(WG_BITS))     err_d = WG_LEN;
                        else if (!parity_ok(shreg_q))          err_d = WG_PAR;
                        else                                   err_d = WG_OK;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                        fault_d   = 1'b0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                if (s == 2'b00) begin
                    gap_d = '0;
                    if (width_q >= W_MIN || busy_q) begin
                        state_d = ST_GAP;
                    end else begin
                        // Glitch with no frame in progress leaves no trace at all.
                        state_d = ST_IDLE;
                        fault_d = 1'b0;
                    end
                end else begin
                    width_d = width_inc(width_q);
                    if (s == 2'b11 || width_q >= W_MAX) fault_d = 1'b1;
                    if (s == line_q && s != 2'b11 && width_q == W_ACCEPT) begin
                        shreg_d   = {shreg_q[WG_BITS-2:0], s[1]};
                        bit_cnt_d = cnt_inc(bit_cnt_q);
                        busy_d    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARMED;
            width_q   <= '0;
            gap_q     <= '0;
            line_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            data_q    <= '0;
            err_q     <= WG_OK;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            gap_q     <= gap_d;
            line_q    <= line_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign valid    = (state_q == ST_DONE);
    assign data     = data_q;
    assign id       = data_q[WG_ID_BITS:1];
    assign err_code = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_wiegand_in.sv
// Bench for wiegand_in: table of frames driven through a scoreboard, plus
// hand-written reset sequences.
module tb_wiegand_in;

    localparam int MIN_P  = 20;
    localparam int MAX_P  = 200;
    localparam int GAP_T  = 400;
    localparam int PULSE  = 50;
    localparam int PERIOD = 150;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wigend;
    logic [25:0] data;
    logic [23:0] id;
    logic        valid;
    logic [1:0]  err_code;
    logic        busy;

    wiegand_in #(
        .MIN_PULSE   (MIN_P),
        .MAX_PULSE   (MAX_P),
        .GAP_TIMEOUT (GAP_T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wigend   (wigend),
        .data     (data),
        .id       (id),
        .valid    (valid),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] bits;
        int          nbits;
        int          mode;
        logic [25:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [25:0] data;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_fall = 0;
    int   nvalid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [25:0] d, input logic [1:0] e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // mode 0: plain frame; mode 1: 10-cycle glitch on wigend[1] in the gap after bit 10;
    // mode 2: bit 5 replaced by both lines high for 100 cycles.
    task automatic send_frame(input logic [26:0] bits, input int nbits, input int mode);
        for (int i = nbits - 1; i >= 0; i--) begin
            int idx;
            int hi;
            idx = nbits - 1 - i;
            hi  = (mode == 2 && idx == 5) ? 100 : PULSE;
            @(negedge clk);
            if (mode == 2 && idx == 5) wigend = 2'b11;
            else                       wigend = bits[i] ? 2'b10 : 2'b01;
            repeat (hi) @(negedge clk);
            wigend    = 2'b00;
            last_fall = cyc;
            for (int k = 0; k < PERIOD - hi - 1; k++) begin
                @(negedge clk);
                if (idx == 0 && k == 5) check("busy_after_first_bit", 32'(busy), 32'd1);
                if (mode == 1 && idx == 10 && k == 40) wigend = 2'b10;
                if (mode == 1 && idx == 10 && k == 50) wigend = 2'b00;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        int n0;
        k  = 0;
        n0 = nvalid;
        while (sb.size() != 0 && k < GAP_T + 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: pending=%0d required=0", name, sb.size());
            sb.delete();
        end
        repeat (20) @(negedge clk);
        check({name, "_valid_count"}, 32'(nvalid - n0), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_id"}, 32'(id), 32'd0);
        check({tag, "_err"}, 32'(err_code), 32'd0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (valid) begin
            nvalid++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: data=%0h err=%0d required no frame", data, err_code);
            end else begin
                e = sb.pop_front();
                check("data", 32'(data), 32'(e.data));
                check("id", 32'(id), 32'(e.data[24:1]));
                check("err_code", 32'(err_code), 32'(e.err));
                check("valid_latency", 32'(cyc - last_fall), 32'(GAP_T + 3));
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        wigend = 2'b00;

        vecs[0] = '{27'h0000002, 26, 0, 26'h0000002, 2'd0};
        vecs[1] = '{27'h0000003, 26, 0, 26'h0000003, 2'd1};
        vecs[2] = '{27'h0000001, 25, 0, 26'h0000001, 2'd2};
        vecs[3] = '{27'h4000002, 27, 0, 26'h0000002, 2'd2};
        vecs[4] = '{27'h0000002, 26, 1, 26'h0000002, 2'd0};
        vecs[5] = '{27'h0000002, 26, 2, 26'h0000002, 2'd3};
        vecs[6] = '{27'h02468AC, 26, 0, 26'h02468AC, 2'd0};
        vecs[7] = '{27'h1FFFFFF, 26, 0, 26'h1FFFFFF, 2'd0};
        vecs[8] = '{27'h2000002, 26, 0, 26'h2000002, 2'd1};

        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            expect_frame(vecs[i].exp_data, vecs[i].exp_err);
            send_frame(vecs[i].bits, vecs[i].nbits, vecs[i].mode);
            wait_drain($sformatf("vec%0d", i));
        end

        // Reset in the middle of bit 12: the partial frame must vanish.
        begin
            int n0;
            send_frame(27'(26'h02468AC >> 14), 12, 0);
            @(negedge clk);
            wigend = 2'b01;
            repeat (25) @(negedge clk);
            n0  = nvalid;
            rst = 1'b1;
            @(negedge clk);
            check_reset_state("midrst");
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (25) @(negedge clk);
            wigend = 2'b00;
            repeat (GAP_T + 100) @(negedge clk);
            check("no_valid_after_midrst", 32'(nvalid - n0), 32'd0);
        end
        expect_frame(26'h02468AC, 2'd0);
        send_frame(27'h02468AC, 26, 0);
        wait_drain("after_midrst");

        // Reset released while wigend[0] is already high: that pulse is ignored.
        wigend = 2'b01;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("busy_line_high_at_release", 32'(busy), 32'd0);
        wigend = 2'b00;
        repeat (30) @(negedge clk);
        check("busy_after_ignored_pulse", 32'(busy), 32'd0);
        expect_frame(26'h1FFFFFF, 2'd0);
        send_frame(27'h1FFFFFF, 26, 0);
        wait_drain("after_hirst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
